// File: rtl/ahb3lite_pkg.sv
`default_nettype none
// ahb3lite_pkg -- shared AHB3-Lite encodings (HTRANS/HSIZE/HBURST/HPROT).
// Rev 1.0
package ahb3lite_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE    = 3'b000;
  localparam logic [2:0] HSIZE_HALF    = 3'b001;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Data access, non-bufferable, non-cacheable; bit 1 is the privileged flag.
  localparam logic [3:0] HPROT_DATA_USER = 4'b0001;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;
endpackage
`default_nettype wire

// File: rtl/riscv_dmem_ahb_pkg.sv
`default_nettype none
// riscv_dmem_ahb_pkg -- FSM state type and byte-enable decode for riscv_dmem_ahb.
// Rev 1.0
package riscv_dmem_ahb_pkg;
  import ahb3lite_pkg::*;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  typedef struct packed {
    logic [2:0] size;
    logic [1:0] off;
  } be_dec_t;

  // Irregular enable patterns fall back to a full aligned word.
  function automatic be_dec_t be_decode(input logic [3:0] be);
    be_dec_t d;
    case (be)
      4'b1111: d = '{size: HSIZE_WORD, off: 2'd0};
      4'b0011: d = '{size: HSIZE_HALF, off: 2'd0};
      4'b1100: d = '{size: HSIZE_HALF, off: 2'd2};
      4'b0001: d = '{size: HSIZE_BYTE, off: 2'd0};
      4'b0010: d = '{size: HSIZE_BYTE, off: 2'd1};
      4'b0100: d = '{size: HSIZE_BYTE, off: 2'd2};
      4'b1000: d = '{size: HSIZE_BYTE, off: 2'd3};
      default: d = '{size: HSIZE_WORD, off: 2'd0};
    endcase
    return d;
  endfunction
endpackage
`default_nettype wire

// File: rtl/riscv_dmem_ahb.sv
`default_nettype none
// riscv_dmem_ahb -- single-outstanding data-memory bridge onto AHB3-Lite.
// Rev 1.0
module riscv_dmem_ahb
  import ahb3lite_pkg::*;
  import riscv_dmem_ahb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cache_req,
  input  logic [XLEN-1:0]   cache_adr,
  input  logic              cache_we,
  input  logic [XLEN-1:0]   cache_d,
  input  logic [XLEN/8-1:0] cache_be,
  input  logic [1:0]        cache_prv,
  input  logic              cache_flush,
  output logic [XLEN-1:0]   cache_q,
  output logic              cache_ack,
  output logic              cache_err,
  output logic [XLEN-1:0]   HADDR,
  output logic [XLEN-1:0]   HWDATA,
  input  logic [XLEN-1:0]   HRDATA,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [1:0]        HTRANS,
  output logic              HMASTLOCK,
  input  logic              HREADY,
  input  logic              HRESP
);

  state_t          r_state;
  state_t          w_next;
  logic [XLEN-1:0] r_d;
  logic            w_ack;
  logic            w_accept;
  logic            w_start;
  be_dec_t         w_dec;
  logic            w_unused;

  // Byte offset comes from the enables, so the low address bits are not used.
  assign w_unused  = ^cache_adr[1:0];
  assign w_dec     = be_decode(cache_be);
  assign w_ack     = (r_state == ST_FLUSH) || (r_state == ST_DATA && HREADY);
  assign w_accept  = cache_req && (r_state == ST_IDLE || w_ack);
  assign w_start   = w_accept && !cache_flush;
  assign HBURST    = HBURST_SINGLE;
  assign HMASTLOCK = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_ADDR: if (HREADY) w_next = ST_DATA;
      default: begin
        if (r_state == ST_IDLE || w_ack) begin
          if (w_accept) w_next = cache_flush ? ST_FLUSH : ST_ADDR;
          else          w_next = ST_IDLE;
        end
      end
    endcase
  end

  // HWRITE still describes the transfer in its data phase when it completes.
  always_comb begin
    cache_ack = w_ack;
    cache_err = (r_state == ST_DATA) && HREADY && HRESP;
    cache_q   = '0;
    if (r_state == ST_DATA && HREADY && !HWRITE) cache_q = HRDATA;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      HTRANS <= HTRANS_IDLE;
      HADDR  <= '0;
      HWDATA <= '0;
      HWRITE <= 1'b0;
      HSIZE  <= HSIZE_WORD;
      HPROT  <= HPROT_DATA_PRIV;
      r_d    <= '0;
    end else if (w_start) begin
      HTRANS <= HTRANS_NONSEQ;
      HADDR  <= {cache_adr[XLEN-1:2], w_dec.off};
      HWRITE <= cache_we;
      HSIZE  <= w_dec.size;
      HPROT  <= (cache_prv != 2'b00) ? HPROT_DATA_PRIV : HPROT_DATA_USER;
      r_d    <= cache_d;
    end else if (r_state == ST_ADDR && HREADY) begin
      HTRANS <= HTRANS_IDLE;
      HWDATA <= r_d;
    end
  end

  a_req_only_when_free: assert property (@(posedge clk) disable iff (rst)
    cache_req |-> (r_state == ST_IDLE || w_ack));

endmodule
`default_nettype wire
